syn_branch_predictor: RTL
=========================

Name: syn_branch_predictor

Overview:
- Fetch-side dynamic branch predictor for the 5-stage pipelined CPU. Sits directly upstream of the PC register and IF/ID latch.
- Looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and supplies the predicted next PC.
- Carries each prediction alongside the instruction through the IF/ID and ID/EX slots. In EX it compares the prediction against the branch/jump unit's actual outcome, then raises mispredict and the recovery PC.

Parameters:
ADDR_BIT, 10, instruction word-address width (matches instruction memory address width)
IDX_BIT, 4, log2 of BTB entry count (16 entries); tag width = ADDR_BIT - IDX_BIT

Ports:
clk  input  1  clock
rst_n  input  1  reset; synchronous, active-low
en  input  1  global enable; low freezes all state
stall  input  1  pipeline stall (load-use bubble or halt); holds IF/ID slot, clears ID/EX slot
flush  input  1  external flush of both tracking slots
if_pc  input  ADDR_BIT  current fetch word address
pred_pc  output  ADDR_BIT  predicted next fetch address
pred_taken  output  1  lookup hit with counter[1]=1
ex_is_ctrl  input  1  instruction in EX is a branch or jump
ex_taken  input  1  actual outcome in EX (ignored if ex_is_ctrl=0)
ex_target  input  ADDR_BIT  actual target in EX
mispredict  output  1  EX slot prediction wrong
recover_pc  output  ADDR_BIT  correct next PC when mispredict=1

Behaviour:
- Entry fields: valid, tag, target[ADDR_BIT], ctr[2].
- Index is if_pc[IDX_BIT-1:0]; tag is if_pc[ADDR_BIT-1:IDX_BIT].
- Lookup is combinational from registered state:
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_pc = pred_taken ? target : if_pc+1, modulo 2^ADDR_BIT (0x3FF+1 wraps to 0).
- Tracking slots S1 (IF/ID) and S2 (ID/EX) each hold {v, pc, pred_taken, pred_pc}.
- Slot update priority on each edge:
  1. !rst_n: all entries valid=0, ctr=2'b01, target=0. S1.v=S2.v=0.
  2. !en: nothing changes.
  3. mispredict || flush: S1.v=0, S2.v=0.
  4. stall: S1 held, S2.v=0.
  5. Otherwise: S1 <= {1, if_pc, pred_taken, pred_pc}; S2 <= S1.
- Resolution is combinational on S2:
  - act_taken = ex_is_ctrl && ex_taken.
  - mispredict = S2.v && (S2.pred_taken != act_taken || (act_taken && S2.pred_pc != ex_target)).
  - recover_pc = act_taken ? ex_target : S2.pc+1 (wraps).
  - When S2.v=0, mispredict=0 and recover_pc=0.
- Table update applies only on an edge with en && S2.v && ex_is_ctrl, at index/tag of S2.pc:
  - Hit: ctr saturating +1 if taken, −1 if not (floor 00, ceiling 11). If taken, target <= ex_target.
  - Miss and taken: allocate/replace with valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not taken: no change.
- A lookup of the same index in the same cycle as an update sees the pre-update entry; the new value is visible on the next cycle.
- Non-control instruction predicted taken (only via tag alias): mispredict with recover_pc=pc+1. The table is not updated.
- Latency:
  - Prediction: 0 cycles.
  - Resolution: two accepted fetches after lookup.
  - Table write: one edge after resolution.
- Reset mid-operation: all predictions are lost and outputs drop to reset values the following cycle. Reset-state outputs: pred_taken=0, pred_pc=if_pc+1, mispredict=0, recover_pc=0.

Optional Feature:
- Macro: BP_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0]. Both clear on reset.
- Each counts, by +1 on an en edge:
  - stat_branches: S2.v && ex_is_ctrl.
  - stat_mispredicts: mispredict.
- Both saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then if_pc=0x010 -> pred_taken=0, pred_pc=0x011. After two accepted fetches with ex_is_ctrl=0 -> mispredict=0, no allocation.
- Branch at 0x020 resolves taken to 0x005 (first time) -> mispredict=1, recover_pc=0x005. Next lookup of 0x020 -> pred_taken=1, pred_pc=0x005 (ctr=10).
- Same branch resolves not-taken twice -> first resolution mispredict=1, recover_pc=0x021, ctr 10->01. Next lookup pred_taken=0. Second not-taken -> ctr 00, no mispredict.
- Taken four times after allocation -> ctr saturates at 11; a single not-taken then gives ctr=10 and prediction still taken.
- stall=1 for 3 cycles with valid S1 -> S1.pc held, S2.v=0, mispredict=0. flush=1 -> both slots empty next cycle.
- if_pc=0x3FF, miss -> pred_pc=0x000. Entry at index 3, tag A; lookup index 3, tag B -> hit=0. With BP_STATS_EN: 5 branches, 2 mispredicts -> stat_branches=5, stat_mispredicts=2.

Source files
------------

// File: rtl/syn_branch_predictor_if.sv
// Fetch/EX-side bus of the branch predictor: fetch lookup, EX resolution and pipeline control.
// Optional statistics outputs appear when BP_STATS_EN is defined.
`timescale 1ns/1ps
interface syn_branch_predictor_if #(parameter int ADDR_BIT = 10);
    logic                en;
    logic                stall;
    logic                flush;
    logic [ADDR_BIT-1:0] if_pc;
    logic [ADDR_BIT-1:0] pred_pc;
    logic                pred_taken;
    logic                ex_is_ctrl;
    logic                ex_taken;
    logic [ADDR_BIT-1:0] ex_target;
    logic                mispredict;
    logic [ADDR_BIT-1:0] recover_pc;
`ifdef BP_STATS_EN
    logic [31:0]         stat_branches;
    logic [31:0]         stat_mispredicts;
`endif

    modport master (
        output en, stall, flush, if_pc, ex_is_ctrl, ex_taken, ex_target,
        input  pred_pc, pred_taken, mispredict, recover_pc
`ifdef BP_STATS_EN
        , input stat_branches, stat_mispredicts
`endif
    );

    modport slave (
        input  en, stall, flush, if_pc, ex_is_ctrl, ex_taken, ex_target,
        output pred_pc, pred_taken, mispredict, recover_pc
`ifdef BP_STATS_EN
        , output stat_branches, stat_mispredicts
`endif
    );
endinterface

// File: rtl/syn_branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, IF/ID and ID/EX prediction tracking, EX-stage resolution.
// Optional feature macro: BP_STATS_EN (branch / mispredict statistics counters).
`timescale 1ns/1ps
module syn_branch_predictor #(
    parameter int ADDR_BIT = 10,
    parameter int IDX_BIT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    syn_branch_predictor_if.slave bp
);
    localparam int TAG_BIT = ADDR_BIT - IDX_BIT;
    localparam int ENTRIES = 1 << IDX_BIT;
    localparam logic [ADDR_BIT-1:0] PC_ONE  = {{(ADDR_BIT-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BIT-1:0] PC_ZERO = {ADDR_BIT{1'b0}};

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic                valid_r  [ENTRIES];
    logic [TAG_BIT-1:0]  tag_r    [ENTRIES];
    logic [ADDR_BIT-1:0] target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];

    logic                s1_v_r, s2_v_r;
    logic [ADDR_BIT-1:0] s1_pc_r, s2_pc_r;
    logic                s1_pt_r, s2_pt_r;
    logic [ADDR_BIT-1:0] s1_ppc_r, s2_ppc_r;

    logic [IDX_BIT-1:0]  look_idx_s;
    logic                look_hit_s;
    logic                pred_taken_s;
    logic [ADDR_BIT-1:0] pred_pc_s;
    logic                act_taken_s;
    logic                mispredict_s;
    logic [ADDR_BIT-1:0] recover_pc_s;
    logic [IDX_BIT-1:0]  upd_idx_s;
    logic [TAG_BIT-1:0]  upd_tag_s;
    logic                upd_en_s;
    logic                upd_hit_s;

    // Fetch-side lookup against registered table contents
    always_comb begin
        look_idx_s   = bp.if_pc[IDX_BIT-1:0];
        look_hit_s   = valid_r[look_idx_s] && (tag_r[look_idx_s] == bp.if_pc[ADDR_BIT-1:IDX_BIT]);
        pred_taken_s = look_hit_s && ctr_r[look_idx_s][1];
        if (pred_taken_s) begin
            pred_pc_s = target_r[look_idx_s];
        end else begin
            pred_pc_s = bp.if_pc + PC_ONE;
        end
    end

    // EX-stage resolution of the prediction carried in the ID/EX slot
    always_comb begin
        act_taken_s  = bp.ex_is_ctrl && bp.ex_taken;
        mispredict_s = 1'b0;
        recover_pc_s = PC_ZERO;
        if (s2_v_r) begin
            mispredict_s = (s2_pt_r != act_taken_s) ||
                           (act_taken_s && (s2_ppc_r != bp.ex_target));
            recover_pc_s = act_taken_s ? bp.ex_target : (s2_pc_r + PC_ONE);
        end else begin
            mispredict_s = 1'b0;
            recover_pc_s = PC_ZERO;
        end
    end

    // Table write port addressed by the resolving instruction's PC
    always_comb begin
        upd_idx_s = s2_pc_r[IDX_BIT-1:0];
        upd_tag_s = s2_pc_r[ADDR_BIT-1:IDX_BIT];
        upd_en_s  = bp.en && s2_v_r && bp.ex_is_ctrl;
        upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    end

    assign bp.pred_taken = pred_taken_s;
    assign bp.pred_pc    = pred_pc_s;
    assign bp.mispredict = mispredict_s;
    assign bp.recover_pc = recover_pc_s;

    // BTB storage: counter training, target refresh, allocation on taken miss
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_BIT{1'b0}};
                target_r[i] <= PC_ZERO;
                ctr_r[i]    <= 2'b01;
            end
        end else if (upd_en_s) begin
            if (upd_hit_s) begin
                if (bp.ex_taken) begin
                    ctr_r[upd_idx_s]    <= ctr_inc(ctr_r[upd_idx_s]);
                    target_r[upd_idx_s] <= bp.ex_target;
                end else begin
                    ctr_r[upd_idx_s]    <= ctr_dec(ctr_r[upd_idx_s]);
                end
            end else if (bp.ex_taken) begin
                valid_r[upd_idx_s]  <= 1'b1;
                tag_r[upd_idx_s]    <= upd_tag_s;
                target_r[upd_idx_s] <= bp.ex_target;
                ctr_r[upd_idx_s]    <= 2'b10;
            end
        end
    end

    // IF/ID and ID/EX prediction tracking slots
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_pc_r  <= PC_ZERO;
            s1_pt_r  <= 1'b0;
            s1_ppc_r <= PC_ZERO;
            s2_v_r   <= 1'b0;
            s2_pc_r  <= PC_ZERO;
            s2_pt_r  <= 1'b0;
            s2_ppc_r <= PC_ZERO;
        end else if (bp.en) begin
            if (mispredict_s || bp.flush) begin
                s1_v_r <= 1'b0;
                s2_v_r <= 1'b0;
            end else if (bp.stall) begin
                s2_v_r <= 1'b0;
            end else begin
                s1_v_r   <= 1'b1;
                s1_pc_r  <= bp.if_pc;
                s1_pt_r  <= pred_taken_s;
                s1_ppc_r <= pred_pc_s;
                s2_v_r   <= s1_v_r;
                s2_pc_r  <= s1_pc_r;
                s2_pt_r  <= s1_pt_r;
                s2_ppc_r <= s1_ppc_r;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] stat_br_r, stat_mp_r;

    // Saturating resolution statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_r <= 32'h0000_0000;
            stat_mp_r <= 32'h0000_0000;
        end else if (bp.en) begin
            if (s2_v_r && bp.ex_is_ctrl && (stat_br_r != 32'hFFFF_FFFF)) begin
                stat_br_r <= stat_br_r + 32'h0000_0001;
            end
            if (mispredict_s && (stat_mp_r != 32'hFFFF_FFFF)) begin
                stat_mp_r <= stat_mp_r + 32'h0000_0001;
            end
        end
    end

    assign bp.stat_branches    = stat_br_r;
    assign bp.stat_mispredicts = stat_mp_r;
`endif
endmodule
